// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Purpose: steps each instruction of the 16-bit, 3-bit-opcode CPU through a
// clocked FSM. It handshakes with a shared instruction/data memory port and
// drives per-state datapath strobes.
//
// Ports:
//   Clk, Rst_N     clock, asynchronous active-low reset
//   Run            allow fetching (sampled in IDLE and at retirement)
//   Opcode         IR[15:13], latched into op_q in DECODE
//   Zero           ALU zero flag (used by BEQ in EXEC)
//   Mem_Ready      memory completes the current request this cycle
//   Mem_Req        memory request (FETCH / MEM)
//   IR_Write       load instruction register
//   PC_Write       update PC
//   Alu_Src        ALU operand B = immediate
//   Branch, Jump   PC target select
//   Mem_Write      memory request is a write
//   Reg_Write      register file write
//   Mem_To_Reg     writeback data from memory
//   Reg_Dst        destination register select
//   Busy           FSM not in IDLE
//   Instr_Done     one-cycle retirement pulse
//   Err            sticky memory-timeout flag
//   Instr_Count    retired-instruction counter (wraps)
module multicycle_sequencer #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst_N,
   input  logic             Run,
   input  logic [2:0]       Opcode,
   input  logic             Zero,
   input  logic             Mem_Ready,
   output logic             Mem_Req,
   output logic             IR_Write,
   output logic             PC_Write,
   output logic             Alu_Src,
   output logic             Branch,
   output logic             Jump,
   output logic             Mem_Write,
   output logic             Reg_Write,
   output logic             Mem_To_Reg,
   output logic             Reg_Dst,
   output logic             Busy,
   output logic             Instr_Done,
   output logic             Err,
   output logic [CNT_W-1:0] Instr_Count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_ERR
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   localparam logic [2:0] OP_BEQ = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_LW  = 3'b110;
   localparam logic [2:0] OP_J   = 3'b111;

   state_t           state;
   logic [2:0]       op_q;
   logic [7:0]       wait_cnt;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   // Strobes are a pure function of state, op_q, Zero and Mem_Ready, so an
   // asynchronous reset (state -> IDLE) drops every strobe immediately.
   // DECODE looks at Opcode directly because op_q is only being loaded there.
   always_comb begin
      Mem_Req    = 1'b0;
      IR_Write   = 1'b0;
      PC_Write   = 1'b0;
      Alu_Src    = 1'b0;
      Branch     = 1'b0;
      Jump       = 1'b0;
      Mem_Write  = 1'b0;
      Reg_Write  = 1'b0;
      Mem_To_Reg = 1'b0;
      Reg_Dst    = 1'b0;
      Instr_Done = 1'b0;
      case (state)
         S_FETCH: begin
            Mem_Req  = 1'b1;
            IR_Write = Mem_Ready;
            PC_Write = Mem_Ready;
         end
         S_DECODE: begin
            if (Opcode == OP_J) begin
               Jump       = 1'b1;
               PC_Write   = 1'b1;
               Instr_Done = 1'b1;
            end
         end
         S_EXEC: begin
            Alu_Src = (op_q == 3'b001) || (op_q == OP_BEQ) ||
                      (op_q == OP_SW)  || (op_q == OP_LW);
            if (op_q == OP_BEQ) begin
               Branch     = 1'b1;
               PC_Write   = Zero;
               Instr_Done = 1'b1;
            end
         end
         S_MEM: begin
            Mem_Req    = 1'b1;
            Mem_Write  = (op_q == OP_SW);
            Instr_Done = Mem_Ready && (op_q == OP_SW);
         end
         S_WB: begin
            Reg_Write  = 1'b1;
            Reg_Dst    = 1'b1;
            Mem_To_Reg = (op_q == OP_LW);
            Instr_Done = 1'b1;
         end
         default: ;
      endcase
   end

   assign Busy        = (state != S_IDLE);
   assign Err         = err_q;
   assign Instr_Count = cnt_q;

   // wait_cnt defaults to zero every cycle and only counts while a memory
   // request is stalled, so it is always zero on entry to FETCH or MEM.
   // A stall is judged against the pre-increment count: Mem_Ready arriving in
   // the cycle the count equals the limit is still a success.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state    <= S_IDLE;
         op_q     <= 3'b000;
         wait_cnt <= 8'd0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wait_cnt <= 8'd0;
         if (Instr_Done) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (Run) state <= S_FETCH;
            end
            S_FETCH: begin
               if (Mem_Ready) begin
                  state <= S_DECODE;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state <= S_ERR;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               op_q <= Opcode;
               if (Opcode == OP_J) state <= Run ? S_FETCH : S_IDLE;
               else                state <= S_EXEC;
            end
            S_EXEC: begin
               case (op_q)
                  3'b000, 3'b001, 3'b010, 3'b011: state <= S_WB;
                  OP_BEQ:                         state <= Run ? S_FETCH : S_IDLE;
                  OP_SW, OP_LW:                   state <= S_MEM;
                  default:                        state <= S_IDLE;
               endcase
            end
            S_MEM: begin
               if (Mem_Ready) begin
                  if (op_q == OP_SW) state <= Run ? S_FETCH : S_IDLE;
                  else               state <= S_WB;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state <= S_ERR;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB: begin
               state <= Run ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

   logic        Clk;
   logic        Rst_N;
   logic        Run;
   logic [2:0]  Opcode;
   logic        Zero;
   logic        Mem_Ready;
   logic        Mem_Req, IR_Write, PC_Write, Alu_Src, Branch, Jump;
   logic        Mem_Write, Reg_Write, Mem_To_Reg, Reg_Dst, Busy, Instr_Done, Err;
   logic [15:0] Instr_Count;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_sequencer #(.MAX_WAIT(15), .CNT_W(16)) dut (
      .Clk(Clk), .Rst_N(Rst_N), .Run(Run), .Opcode(Opcode), .Zero(Zero),
      .Mem_Ready(Mem_Ready), .Mem_Req(Mem_Req), .IR_Write(IR_Write),
      .PC_Write(PC_Write), .Alu_Src(Alu_Src), .Branch(Branch), .Jump(Jump),
      .Mem_Write(Mem_Write), .Reg_Write(Reg_Write), .Mem_To_Reg(Mem_To_Reg),
      .Reg_Dst(Reg_Dst), .Busy(Busy), .Instr_Done(Instr_Done), .Err(Err),
      .Instr_Count(Instr_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {Mem_Req,IR_Write,PC_Write,Alu_Src,Branch,Jump,Mem_Write,
   //  Reg_Write,Mem_To_Reg,Reg_Dst,Busy,Instr_Done,Err}
   logic [12:0] outs;
   assign outs = {Mem_Req, IR_Write, PC_Write, Alu_Src, Branch, Jump, Mem_Write,
                  Reg_Write, Mem_To_Reg, Reg_Dst, Busy, Instr_Done, Err};

   localparam logic [12:0] V_ZERO   = 13'b0000000000000;
   localparam logic [12:0] V_FRDY   = 13'b1110000000100;
   localparam logic [12:0] V_FWAIT  = 13'b1000000000100;
   localparam logic [12:0] V_BUSY   = 13'b0000000000100;
   localparam logic [12:0] V_DEC_J  = 13'b0010010000110;
   localparam logic [12:0] V_BEQ_T  = 13'b0011100000110;
   localparam logic [12:0] V_BEQ_N  = 13'b0001100000110;
   localparam logic [12:0] V_EX_MEM = 13'b0001000000100;
   localparam logic [12:0] V_MEM_LW = 13'b1000000000100;
   localparam logic [12:0] V_MEM_SW = 13'b1000001000110;
   localparam logic [12:0] V_WB_R   = 13'b0000000101110;
   localparam logic [12:0] V_WB_LW  = 13'b0000000111110;
   localparam logic [12:0] V_ERR    = 13'b0000000000101;

   task automatic chk_outs(input logic [12:0] exp, input string tag);
      n_assert++;
      assert (outs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
   endtask

   task automatic chk_cnt(input logic [15:0] exp, input string tag);
      n_assert++;
      assert (Instr_Count === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, Instr_Count, exp);
      end
   endtask

   // Entered and left at posedge+1: drive inputs, let outputs settle, check.
   task automatic cyc(input logic [2:0] op, input logic rdy, input logic z,
                      input logic run, input logic [12:0] exp, input string tag);
      Opcode    = op;
      Mem_Ready = rdy;
      Zero      = z;
      Run       = run;
      #1;
      chk_outs(exp, tag);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst_N = 1'b0; Run = 1'b0; Opcode = 3'b000; Zero = 1'b0; Mem_Ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk_outs(V_ZERO, "reset_outputs");
      chk_cnt(16'd0, "reset_count");
      Rst_N = 1'b1;

      // ADD, zero wait states: 4 cycles, writeback only in cycle 4
      cyc(3'b000, 1, 0, 1, V_ZERO, "add_idle");
      cyc(3'b000, 1, 0, 1, V_FRDY, "add_fetch");
      cyc(3'b000, 1, 0, 1, V_BUSY, "add_decode");
      cyc(3'b000, 1, 0, 1, V_BUSY, "add_exec");
      cyc(3'b000, 1, 0, 1, V_WB_R, "add_wb");
      chk_cnt(16'd1, "add_count");

      // BEQ taken, then not taken
      cyc(3'b100, 1, 1, 1, V_FRDY,  "beq_t_fetch");
      cyc(3'b100, 1, 1, 1, V_BUSY,  "beq_t_decode");
      cyc(3'b100, 1, 1, 1, V_BEQ_T, "beq_t_exec");
      cyc(3'b100, 1, 0, 1, V_FRDY,  "beq_n_fetch");
      cyc(3'b100, 1, 0, 1, V_BUSY,  "beq_n_decode");
      cyc(3'b100, 1, 0, 1, V_BEQ_N, "beq_n_exec");
      chk_cnt(16'd3, "beq_count");

      // LW with 3 memory wait cycles: 8 cycles total
      cyc(3'b110, 1, 0, 1, V_FRDY,   "lw_fetch");
      cyc(3'b110, 1, 0, 1, V_BUSY,   "lw_decode");
      cyc(3'b110, 1, 0, 1, V_EX_MEM, "lw_exec");
      for (int i = 0; i < 3; i++) cyc(3'b110, 0, 0, 1, V_MEM_LW, "lw_mem_wait");
      cyc(3'b110, 1, 0, 1, V_MEM_LW, "lw_mem_ready");
      cyc(3'b110, 1, 0, 1, V_WB_LW,  "lw_wb");
      chk_cnt(16'd4, "lw_count");

      // SW then J back-to-back
      cyc(3'b101, 1, 0, 1, V_FRDY,   "sw_fetch");
      cyc(3'b101, 1, 0, 1, V_BUSY,   "sw_decode");
      cyc(3'b101, 1, 0, 1, V_EX_MEM, "sw_exec");
      cyc(3'b101, 1, 0, 1, V_MEM_SW, "sw_mem");
      cyc(3'b111, 1, 0, 1, V_FRDY,   "j_fetch");
      cyc(3'b111, 1, 0, 1, V_DEC_J,  "j_decode");
      chk_cnt(16'd6, "sw_j_count");

      // Run dropped during LW EXEC: instruction completes, then IDLE
      cyc(3'b110, 1, 0, 1, V_FRDY,   "run_fetch");
      cyc(3'b110, 1, 0, 1, V_BUSY,   "run_decode");
      cyc(3'b110, 1, 0, 0, V_EX_MEM, "run_exec");
      cyc(3'b110, 1, 0, 0, V_MEM_LW, "run_mem");
      cyc(3'b110, 1, 0, 0, V_WB_LW,  "run_wb");
      cyc(3'b110, 1, 0, 0, V_ZERO,   "run_idle");
      cyc(3'b110, 1, 0, 0, V_ZERO,   "run_idle_hold");
      chk_cnt(16'd7, "run_count");

      // Mem_Ready exactly when the wait count reaches 15: success
      cyc(3'b111, 0, 0, 1, V_ZERO, "to_idle");
      for (int i = 0; i < 15; i++) cyc(3'b111, 0, 0, 1, V_FWAIT, "to_ok_wait");
      cyc(3'b111, 1, 0, 1, V_FRDY,  "to_ok_at_max");
      cyc(3'b111, 0, 0, 1, V_DEC_J, "to_ok_decode_j");
      chk_cnt(16'd8, "to_ok_count");

      // Mem_Ready held low: error after 15 wait cycles, sticky
      for (int i = 0; i < 15; i++) cyc(3'b000, 0, 0, 1, V_FWAIT, "to_err_wait");
      cyc(3'b000, 0, 0, 1, V_FWAIT, "to_err_last");
      cyc(3'b000, 0, 0, 1, V_ERR,   "to_err_state");
      cyc(3'b000, 1, 0, 1, V_ERR,   "to_err_sticky_rdy");
      cyc(3'b000, 1, 0, 0, V_ERR,   "to_err_sticky_norun");
      chk_cnt(16'd8, "to_err_count");
      Rst_N = 1'b0;
      #1;
      chk_outs(V_ZERO, "to_err_reset");
      chk_cnt(16'd0, "to_err_reset_count");
      @(posedge Clk);
      #1;
      Rst_N = 1'b1;

      // Reset pulsed during WB of an ADD
      cyc(3'b000, 1, 0, 1, V_ZERO, "rst_idle");
      cyc(3'b000, 1, 0, 1, V_FRDY, "rst_fetch");
      cyc(3'b000, 1, 0, 1, V_BUSY, "rst_decode");
      cyc(3'b000, 1, 0, 1, V_BUSY, "rst_exec");
      #1;
      chk_outs(V_WB_R, "rst_wb_before");
      Rst_N = 1'b0;
      #1;
      chk_outs(V_ZERO, "rst_wb_async_drop");
      @(posedge Clk);
      #1;
      chk_cnt(16'd0, "rst_wb_count");
      Rst_N = 1'b1;
      cyc(3'b000, 1, 0, 0, V_ZERO, "rst_after_idle");
      chk_cnt(16'd0, "rst_after_count");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
